// File: rtl/hex_text_scheduler.sv
// hex_text_scheduler
//
// Shares one binary-to-ASCII-hex text path between two requesters. A
// round-robin arbiter grants one pending request, the granted 18-bit value is
// latched, and five ASCII hex characters (most significant first) are streamed
// to the LCD text writer together with their LCD column. A one-cycle ack then
// tells the requester its value has been written.
//
// Handshake: a character transfers on a rising clk edge where
// char_valid && char_ready. While char_valid is high and char_ready is low,
// char_out and char_pos hold their values. char_valid never drops without a
// transfer, except on reset.
//
// Parameters:
//   BASE_POS0  LCD column of requester 0's first character
//   BASE_POS1  LCD column of requester 1's first character
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   req0/req1   request, held until the matching ack
//   value0/1    18-bit value, sampled when the request is loaded
//   ack0/ack1   one-cycle pulse once the 5th character has transferred
//   char_out    ASCII character
//   char_pos    LCD column of char_out (wraps mod 32)
//   char_valid  char_out/char_pos are valid
//   char_ready  downstream can accept a character
//   busy        high whenever the scheduler is not idle
//
// Build option:
//   ZERO_BLANK_EN  when defined, leading zero digits (except the last one)
//                  are printed as spaces.

module hex_text_scheduler #(
  parameter logic [4:0] BASE_POS0 = 5'd0,
  parameter logic [4:0] BASE_POS1 = 5'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [17:0] value0,
  input  logic        req1,
  input  logic [17:0] value1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  char_out,
  output logic [4:0]  char_pos,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_ptr;     // requester that wins when both request
  logic        r_grant;   // requester currently being served
  logic [2:0]  r_index;   // digit being presented, 0 = most significant
  logic [17:0] r_value;
  logic [4:0]  r_base;

  state_t      w_next_state;
  logic        w_take;
  logic        w_win;
  logic        w_hs;
  logic        w_last;
  logic [3:0]  w_nib;
  logic [7:0]  w_ascii;
  logic [7:0]  w_char;

  assign w_hs   = (r_state == S_SEND) && char_ready;
  assign w_last = (r_index == 3'd4);

  // Next-state and arbitration
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_win        = r_grant;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_take       = 1'b1;
          w_win        = (req0 && req1) ? r_ptr : req1;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: w_next_state = S_SEND;
      S_SEND: begin
        if (w_hs && w_last) w_next_state = S_DONE;
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_grant <= 1'b0;
      r_index <= 3'd0;
      r_value <= 18'd0;
      r_base  <= 5'd0;
    end else begin
      r_state <= w_next_state;
      if (w_take) begin
        r_grant <= w_win;
        r_ptr   <= ~w_win;
      end
      if (r_state == S_LOAD) begin
        r_value <= r_grant ? value1 : value0;
        r_base  <= r_grant ? BASE_POS1 : BASE_POS0;
        r_index <= 3'd0;
      end else if (w_hs && !w_last) begin
        r_index <= r_index + 3'd1;
      end
    end
  end

  // Digit select; the top digit only has two bits.
  always_comb begin
    w_nib = 4'd0;
    case (r_index)
      3'd0:    w_nib = {2'b00, r_value[17:16]};
      3'd1:    w_nib = r_value[15:12];
      3'd2:    w_nib = r_value[11:8];
      3'd3:    w_nib = r_value[7:4];
      default: w_nib = r_value[3:0];
    endcase
  end

  // 'A' - 10 = 8'h37
  assign w_ascii = (w_nib < 4'd10) ? (8'h30 + {4'b0000, w_nib})
                                   : (8'h37 + {4'b0000, w_nib});

`ifdef ZERO_BLANK_EN
  logic w_lead_zero;

  // True when this digit and every more significant digit are zero.
  // The last digit is never blanked so a zero value still shows "0".
  always_comb begin
    w_lead_zero = 1'b0;
    case (r_index)
      3'd0:    w_lead_zero = (r_value[17:16] == 2'd0);
      3'd1:    w_lead_zero = (r_value[17:12] == 6'd0);
      3'd2:    w_lead_zero = (r_value[17:8]  == 10'd0);
      3'd3:    w_lead_zero = (r_value[17:4]  == 14'd0);
      default: w_lead_zero = 1'b0;
    endcase
  end

  assign w_char = w_lead_zero ? 8'h20 : w_ascii;
`else
  assign w_char = w_ascii;
`endif

  assign char_valid = (r_state == S_SEND);
  assign char_out   = char_valid ? w_char : 8'h00;
  assign char_pos   = char_valid ? (r_base + {2'b00, r_index}) : 5'd0;
  assign busy       = (r_state != S_IDLE);
  assign ack0       = (r_state == S_DONE) && !r_grant;
  assign ack1       = (r_state == S_DONE) &&  r_grant;

endmodule
